// File: rtl/avg_pool_pkg.sv
// Shared types and size helpers for the average-pooling sequencer.
package avg_pool_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    EMIT  = 3'd3,
    FIN   = 3'd4
  } state_t;

  // floor(log2(v)) for v >= 1
  function automatic int log2_floor(input int v);
    int r;
    r = 0;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) <= v) r = i;
    end
    return r;
  endfunction

  // Index width that never collapses to zero bits
  function automatic int index_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int output_h(input int h, input int p, input int s);
    return (h - p) / s + 1;
  endfunction

  function automatic int output_w(input int w, input int p, input int s);
    return (w - p) / s + 1;
  endfunction

  function automatic int addr_w(input int h, input int w);
    return index_w(h * w);
  endfunction

  // Accumulator width: P*P pixels can add up to P*P*max without wrapping
  function automatic int sum_w(input int dw, input int p);
    return dw + 2 * log2_floor(p);
  endfunction

endpackage

// File: rtl/avg_pool_window_acc.sv
// Window accumulator: sums P*P pixels and presents floor(sum / (P*P)).
module avg_pool_window_acc
  import avg_pool_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int POOL_SIZE  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  add_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] avg
);

  localparam int SUM_W = sum_w(DATA_WIDTH, POOL_SIZE);
  localparam int SHIFT = 2 * log2_floor(POOL_SIZE);

  logic [SUM_W-1:0] acc_q;
  logic [SUM_W-1:0] acc_d;

  // Next accumulator value: clear wins over add
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (add_en) begin
      acc_d = acc_q + {{SHIFT{1'b0}}, din};
    end
  end

  // Accumulator register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  // Dividing by P*P is a right shift by 2*log2(P); the top DATA_WIDTH bits are the mean
  assign avg = acc_q[SHIFT +: DATA_WIDTH];

endmodule

// File: rtl/avg_pool_sequencer.sv
// Average-pool sequencer: walks output windows, reads each window's pixels
// from a 1-cycle-latency frame buffer, and emits the mean over a valid/ready port.
module avg_pool_sequencer
  import avg_pool_pkg::*;
#(
  parameter int H          = 3,
  parameter int W          = 4,
  parameter int POOL_SIZE  = 2,
  parameter int S          = 1,
  parameter int DATA_WIDTH = 4,
  localparam int OUTPUT_H  = output_h(H, POOL_SIZE, S),
  localparam int OUTPUT_W  = output_w(W, POOL_SIZE, S),
  localparam int ADDR_W    = addr_w(H, W),
  localparam int ROW_W     = index_w(OUTPUT_H),
  localparam int COL_W     = index_w(OUTPUT_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ROW_W-1:0]      out_row,
  output logic [COL_W-1:0]      out_col
);

  localparam int K_W = index_w(POOL_SIZE);
  localparam logic [K_W-1:0]   K_LAST  = K_W'(POOL_SIZE - 1);
  localparam logic [COL_W-1:0] OX_LAST = COL_W'(OUTPUT_W - 1);
  localparam logic [ROW_W-1:0] OY_LAST = ROW_W'(OUTPUT_H - 1);

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [COL_W-1:0]  ox_q, ox_d;
  logic [ROW_W-1:0]  oy_q, oy_d;
  logic [K_W-1:0]    kx_q, kx_d;
  logic [K_W-1:0]    ky_q, ky_d;
  logic              add_en_q;
  logic              acc_clr;

  // Row-major pixel address of window element (ky, kx) in output window (oy, ox)
  function automatic logic [ADDR_W-1:0] calc_addr(input int oy, input int ox,
                                                  input int ky, input int kx);
    return ADDR_W'((oy * S + ky) * W + (ox * S + kx));
  endfunction

  // Next-state, counter and registered-output logic
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rd_en_d = 1'b0;
    addr_d  = addr_q;
    valid_d = valid_q;
    row_d   = row_q;
    col_d   = col_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    acc_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          busy_d  = 1'b1;
          rd_en_d = 1'b1;
          ox_d    = '0;
          oy_d    = '0;
          kx_d    = '0;
          ky_d    = '0;
          acc_clr = 1'b1;
          addr_d  = calc_addr(0, 0, 0, 0);
        end
      end
      READ: begin
        // kx/ky name the element being read this cycle; step to the next one
        rd_en_d = 1'b1;
        if (kx_q == K_LAST) begin
          kx_d = '0;
          if (ky_q == K_LAST) begin
            ky_d    = '0;
            rd_en_d = 1'b0;
            state_d = DRAIN;
          end else begin
            ky_d = ky_q + 1'b1;
          end
        end else begin
          kx_d = kx_q + 1'b1;
        end
        if (rd_en_d) addr_d = calc_addr(int'(oy_q), int'(ox_q), int'(ky_d), int'(kx_d));
      end
      DRAIN: begin
        // Last datum lands in the accumulator at the end of this cycle
        state_d = EMIT;
        valid_d = 1'b1;
        row_d   = oy_q;
        col_d   = ox_q;
      end
      EMIT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          acc_clr = 1'b1;
          if (ox_q == OX_LAST) begin
            ox_d = '0;
            oy_d = (oy_q == OY_LAST) ? '0 : oy_q + 1'b1;
          end else begin
            ox_d = ox_q + 1'b1;
          end
          if (ox_q == OX_LAST && oy_q == OY_LAST) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d = READ;
            rd_en_d = 1'b1;
            addr_d  = calc_addr(int'(oy_d), int'(ox_d), 0, 0);
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      kx_q     <= '0;
      ky_q     <= '0;
      add_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_en_q  <= rd_en_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      row_q    <= row_d;
      col_q    <= col_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      kx_q     <= kx_d;
      ky_q     <= ky_d;
      add_en_q <= rd_en_q;  // read data is valid one cycle after the strobe
    end
  end

  avg_pool_window_acc #(
    .DATA_WIDTH(DATA_WIDTH),
    .POOL_SIZE (POOL_SIZE)
  ) u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (acc_clr),
    .add_en(add_en_q),
    .din   (mem_rd_data),
    .avg   (out_data)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_rd_addr = addr_q;
  assign out_valid   = valid_q;
  assign out_row     = row_q;
  assign out_col     = col_q;

endmodule

// File: tb/tb_avg_pool_sequencer.sv
// Scoreboard bench for avg_pool_sequencer: a reference model fills expected
// queues, monitors pop and compare whenever the DUTs read or emit.
module tb_avg_pool_sequencer;

  localparam int H = 3, W = 4, P = 2, S = 1, DW = 4;
  localparam int OH = (H - P) / S + 1;
  localparam int OW = (W - P) / S + 1;
  localparam int AW = $clog2(H * W);
  localparam int RW = (OH > 1) ? $clog2(OH) : 1;
  localparam int CW = (OW > 1) ? $clog2(OW) : 1;

  localparam int H2 = 4, W2 = 4, S2 = 2;
  localparam int OH2 = (H2 - P) / S2 + 1;
  localparam int OW2 = (W2 - P) / S2 + 1;
  localparam int AW2 = $clog2(H2 * W2);
  localparam int RW2 = (OH2 > 1) ? $clog2(OH2) : 1;
  localparam int CW2 = (OW2 > 1) ? $clog2(OW2) : 1;

  typedef struct {
    int data;
    int row;
    int col;
  } exp_t;

  logic clk, rst;
  logic start, busy, done, mem_rd_en, out_valid, out_ready;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data, out_data;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;

  logic start2, busy2, done2, rd_en2, valid2, ready2;
  logic [AW2-1:0] addr2;
  logic [DW-1:0] rd_data2, data2;
  logic [RW2-1:0] row2;
  logic [CW2-1:0] col2;

  logic [DW-1:0] mem0 [0:H*W-1];
  logic [DW-1:0] mem2 [0:H2*W2-1];

  exp_t exp_q[$];
  exp_t exp2_q[$];
  int   exp_addr_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int out_cnt = 0;
  int out2_cnt = 0;
  int done_cnt = 0;
  int done2_cnt = 0;
  bit chk_latency = 0;
  bit rand_ready = 0;

  avg_pool_sequencer #(.H(H), .W(W), .POOL_SIZE(P), .S(S), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col)
  );

  avg_pool_sequencer #(.H(H2), .W(W2), .POOL_SIZE(P), .S(S2), .DATA_WIDTH(DW)) dut_s2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .mem_rd_en(rd_en2), .mem_rd_addr(addr2), .mem_rd_data(rd_data2),
    .out_valid(valid2), .out_ready(ready2), .out_data(data2),
    .out_row(row2), .out_col(col2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Frame buffers with one-cycle read latency
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem0[mem_rd_addr];
  always @(posedge clk) if (rd_en2) rd_data2 <= mem2[addr2];

  // Random backpressure when enabled
  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: every window of the frame, its addresses and its floored mean
  task automatic model_frame();
    for (int oy = 0; oy < OH; oy++) begin
      for (int ox = 0; ox < OW; ox++) begin
        int sum = 0;
        for (int ky = 0; ky < P; ky++) begin
          for (int kx = 0; kx < P; kx++) begin
            int a = (oy * S + ky) * W + (ox * S + kx);
            exp_addr_q.push_back(a);
            sum += int'(mem0[a]);
          end
        end
        exp_q.push_back('{sum / (P * P), oy, ox});
      end
    end
  endtask

  task automatic model_frame2();
    for (int oy = 0; oy < OH2; oy++) begin
      for (int ox = 0; ox < OW2; ox++) begin
        int sum = 0;
        for (int ky = 0; ky < P; ky++)
          for (int kx = 0; kx < P; kx++)
            sum += int'(mem2[(oy * S2 + ky) * W2 + (ox * S2 + kx)]);
        exp2_q.push_back('{sum / (P * P), oy, ox});
      end
    end
  endtask

  // Monitor for the main instance
  always @(negedge clk) begin
    if (!rst) begin
      if (start && !busy) start_cyc = cyc;
      if (mem_rd_en) begin
        check("rd_addr_expected", int'(exp_addr_q.size() > 0), 1);
        if (exp_addr_q.size() > 0) check("rd_addr", int'(mem_rd_addr), exp_addr_q.pop_front());
      end
      if (out_valid) check("no_read_in_emit", int'(mem_rd_en), 0);
      if (out_valid && out_ready) begin
        exp_t e;
        $display("out row=%0d col=%0d data=%0d", out_row, out_col, out_data);
        out_cnt++;
        check("output_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_data", int'(out_data), e.data);
          check("out_row", int'(out_row), e.row);
          check("out_col", int'(out_col), e.col);
        end
      end
      if (done) begin
        done_cnt++;
        if (chk_latency) check("done_latency", cyc - start_cyc, 37);
      end
    end
  end

  // Monitor for the stride-2 instance
  always @(negedge clk) begin
    if (!rst) begin
      if (valid2 && ready2) begin
        exp_t e;
        $display("s2 out row=%0d col=%0d data=%0d", row2, col2, data2);
        out2_cnt++;
        check("s2_output_expected", int'(exp2_q.size() > 0), 1);
        if (exp2_q.size() > 0) begin
          e = exp2_q.pop_front();
          check("s2_out_data", int'(data2), e.data);
          check("s2_out_row", int'(row2), e.row);
          check("s2_out_col", int'(col2), e.col);
        end
      end
      if (done2) done2_cnt++;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_rd_en"}, int'(mem_rd_en), 0);
    check({tag, "_rd_addr"}, int'(mem_rd_addr), 0);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_data"}, int'(out_data), 0);
    check({tag, "_row"}, int'(out_row), 0);
    check({tag, "_col"}, int'(out_col), 0);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("done_seen", int'(done_cnt > d0), 1);
  endtask

  task automatic frame_end_checks();
    check("out_count", out_cnt, OH * OW);
    check("exp_drained", exp_q.size(), 0);
    check("addr_drained", exp_addr_q.size(), 0);
  endtask

  task automatic run_frame(input bit rr, input bit lat);
    model_frame();
    out_cnt = 0;
    chk_latency = lat;
    if (!rr) out_ready = 1'b1;
    rand_ready = rr;
    pulse_start();
    wait_done(3000);
    rand_ready = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    frame_end_checks();
  endtask

  task automatic load_basic();
    int pix[12] = '{1, 2, 3, 4, 6, 5, 6, 5, 7, 8, 9, 5};
    for (int i = 0; i < H * W; i++) mem0[i] = DW'(pix[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    out_ready = 1'b1;
    ready2 = 1'b1;
    load_basic();
    for (int i = 0; i < H2 * W2; i++) mem2[i] = 4'd15;

    // Reset state
    repeat (3) @(negedge clk);
    check_zero("in_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("after_reset");

    // Basic frame with addresses and done latency
    run_frame(1'b0, 1'b1);

    // Backpressure on window (0,1)
    model_frame();
    out_cnt = 0;
    chk_latency = 1'b0;
    pulse_start();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_row == 0 && out_col == 0) && n < 100);
    check("bp_first_window_seen", int'(out_valid), 1);
    @(posedge clk);
    #1 out_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    check("bp_valid_seen", int'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_valid", int'(out_valid), 1);
      check("bp_data", int'(out_data), exp_q[0].data);
      check("bp_row", int'(out_row), exp_q[0].row);
      check("bp_col", int'(out_col), exp_q[0].col);
      check("bp_no_read", int'(mem_rd_en), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done(3000);
    frame_end_checks();

    // Reset during the third window's READ
    model_frame();
    out_cnt = 0;
    pulse_start();
    n = 0;
    begin
      int reads = 0;
      while (reads < 9 && n < 200) begin
        @(negedge clk);
        n++;
        if (mem_rd_en) reads++;
      end
      check("mid_reads_reached", reads, 9);
    end
    #1 rst = 1'b1;
    exp_q.delete();
    exp_addr_q.delete();
    #1 check_zero("mid_reset");
    repeat (2) @(negedge clk);
    check_zero("mid_reset_hold");
    @(posedge clk);
    #1 rst = 1'b0;
    run_frame(1'b0, 1'b1);

    // start while busy, and start coincident with done
    model_frame();
    out_cnt = 0;
    chk_latency = 1'b1;
    pulse_start();
    repeat (15) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("busy_frame_done", int'(done), 1);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("start_with_done_ignored", int'(busy), 0);
    check("no_read_after_done", int'(mem_rd_en), 0);
    frame_end_checks();
    chk_latency = 1'b0;

    // Random frames with random backpressure
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < H * W; i++) mem0[i] = 4'($urandom_range(0, 15));
      run_frame(1'b1, 1'b0);
    end

    // Stride 2 on a 4x4 frame of 15s
    model_frame2();
    out2_cnt = 0;
    @(posedge clk);
    #1 start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    begin
      int d0 = done2_cnt;
      n = 0;
      while (done2_cnt == d0 && n < 500) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("s2_done_seen", int'(done2_cnt > d0), 1);
    end
    check("s2_out_count", out2_cnt, OH2 * OW2);
    check("s2_exp_drained", exp2_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/avg_pool_sequencer.md
AVG_POOL_SEQUENCER -- requirements
Module: avg_pool_sequencer

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- H, 3, input rows.
- W, 4, input columns.
- POOL_SIZE, 2, window edge P; legal values are 2 and 4.
- S, 1, stride.
- DATA_WIDTH, 4, pixel and result width.
REQ-002 The block SHALL use these derived constants:
- OUTPUT_H = (H-P)/S+1.
- OUTPUT_W = (W-P)/S+1.
- ADDR_W = clog2(H*W).
- SUM_W = DATA_WIDTH + 2*log2(P).
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, single-cycle request to pool one frame.
- busy, out, 1, high from start acceptance until done.
- done, out, 1, single-cycle pulse after the last output handshake.
- mem_rd_en, out, 1, frame-buffer read strobe.
- mem_rd_addr, out, ADDR_W, row-major pixel address.
- mem_rd_data, in, DATA_WIDTH, pixel, valid the cycle after mem_rd_en (fixed 1-cycle latency).
- out_valid, out, 1, result available.
- out_ready, in, 1, consumer accepts the result.
- out_data, out, DATA_WIDTH, window average.
- out_row, out, clog2(OUTPUT_H), output row index.
- out_col, out, clog2(OUTPUT_W), output column index.

Function
REQ-004 The FSM SHALL have the states IDLE, READ, DRAIN, EMIT and FIN.
REQ-005 In IDLE, start=1 SHALL clear all counters and the accumulator, set busy, and enter READ on the next edge.
REQ-006 start SHALL be ignored while busy=1.
REQ-007 READ SHALL assert mem_rd_en for exactly P*P consecutive cycles, window elements in row-major order (ky outer, kx inner).
REQ-008 The read address SHALL be mem_rd_addr = (oy*S+ky)*W + (ox*S+kx).
REQ-009 mem_rd_data SHALL be added to the SUM_W-bit accumulator on the cycle after each read strobe, with no overflow possible.
REQ-010 After the last read the FSM SHALL spend one cycle in DRAIN to absorb the final read datum, then enter EMIT.
REQ-011 In EMIT:
- out_valid=1.
- out_data = sum >> (2*log2(P)), i.e. floor of the mean.
- out_row=oy, out_col=ox.
- All outputs held stable until out_ready=1.
REQ-012 On the EMIT handshake (out_valid and out_ready both 1):
- The accumulator SHALL clear.
- ox SHALL increment; on wrap from OUTPUT_W-1 to 0, oy SHALL increment.
- If the window was (OUTPUT_H-1, OUTPUT_W-1), the FSM SHALL enter FIN; otherwise it SHALL enter READ.
REQ-013 FIN SHALL assert done=1 for one cycle, deassert busy, and return to IDLE.
REQ-014 With out_ready held 1, each window SHALL take P*P+2 cycles, and the first mem_rd_en SHALL occur on the cycle after start is sampled.
REQ-015 Backpressure (out_ready=0) SHALL stall only in EMIT; mem_rd_en SHALL be 0 outside READ.
REQ-016 out_valid SHALL be 0 in every state other than EMIT.
REQ-017 A start coincident with done SHALL be ignored.

Reset
REQ-018 Asserting rst at any time, including mid-frame, SHALL immediately force:
- state to IDLE.
- busy, done, mem_rd_en and out_valid to 0.
- mem_rd_addr, out_data, out_row, out_col, counters and accumulator to 0.
REQ-019 After rst deasserts, the block SHALL accept a new start with no residual state.

Structure
REQ-020 A shared package avg_pool_pkg SHALL hold:
- the state enum.
- the OUTPUT_H/OUTPUT_W/ADDR_W/SUM_W helper functions.
REQ-021 The accumulate-and-shift datapath SHALL be a sub-module avg_pool_window_acc (inputs: clr, add_en, din; output: avg).
REQ-022 The FSM, the counters (ox, oy, kx, ky) and the address generation SHALL reside in avg_pool_sequencer.

Verification
REQ-023 Basic frame. Stimulus: 3x4 frame with rows 1 2 3 4 / 6 5 6 5 / 7 8 9 5, P=2, S=1, out_ready=1. Required response: outputs 3 4 4 / 6 7 6 in row-major order, and done 37 cycles after start.
REQ-024 Address check. Stimulus: same frame. Required response: the first window reads addresses 0, 1, 4, 5; the last window reads 6, 7, 10, 11.
REQ-025 Backpressure. Stimulus: hold out_ready=0 for 5 cycles on window (0,1). Required response: out_data=4, out_row=0 and out_col=1 stay stable, and there are no reads while stalled.
REQ-026 Reset mid-frame. Stimulus: assert rst during the third window's READ, then issue a new start. Required response: all outputs are 0 during reset, and the next frame reproduces 3 4 4 / 6 7 6.
REQ-027 start while busy. Stimulus: pulse start mid-frame. Required response: no restart, and exactly 6 outputs are produced.
REQ-028 Stride 2 with P=2 on a 4x4 frame of all 15s. Required response: four outputs of 15 at (0,0), (0,1), (1,0), (1,1).
